// File: rtl/multi_edge_irq_pio_if.sv
// Avalon-MM slave bus bundle for the multi-edge interrupt PIO.
interface multi_edge_irq_pio_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/multi_edge_irq_pio.sv
// Multi-channel input PIO: per-channel synchronizer, glitch filter,
// rise/fall edge capture (sticky, write-1-to-clear) and a masked level irq.
module multi_edge_irq_pio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multi_edge_irq_pio_if.slave  avs,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  filt_q, filt_d;
    logic [FILT_W-1:0] cnt_q  [WIDTH];
    logic [FILT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0]  rise_en_q, fall_en_q, mask_q;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [FILT_W-1:0] flen_q;
    logic [31:0]       rdata_q, rdata_d;

    logic              wr;
    logic [WIDTH-1:0]  sync_w, rise_w, fall_w, clr_w;
    logic              unused_wdata;

    assign wr           = avs.chipselect & ~avs.write_n;
    assign sync_w       = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^avs.writedata;

    // Synchronizer chain: in_port crosses into clk after SYNC_STAGES flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Glitch filter: adopt sync only once it has differed for flen+1 cycles;
    // >= compare lets a lowered length take effect on a running count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_w[i] != filt_q[i]) begin
                if (cnt_q[i] >= flen_q) filt_d[i] = sync_w[i];
                else                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Edge capture: set has priority over a same-cycle W1C clear.
    always_comb begin
        rise_w = filt_d & ~filt_q & rise_en_q;
        fall_w = ~filt_d & filt_q & fall_en_q;
        clr_w  = (wr && avs.address == 3'd3) ? avs.writedata[WIDTH-1:0] : '0;
        cap_d  = (cap_q & ~clr_w) | rise_w | fall_w;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        rdata_d = '0;
        case (avs.address)
            3'd0:    rdata_d = 32'(filt_q);
            3'd1:    rdata_d = 32'(rise_en_q);
            3'd2:    rdata_d = 32'(mask_q);
            3'd3:    rdata_d = 32'(cap_q);
            3'd4:    rdata_d = 32'(fall_en_q);
            3'd5:    rdata_d = 32'(flen_q);
            3'd6:    rdata_d = 32'(cap_q & mask_q);
            default: rdata_d = '0;
        endcase
    end

    // Filter state and capture bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            cap_q  <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            cap_q  <= cap_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Software-writable control registers and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            mask_q    <= '0;
            flen_q    <= '0;
            rdata_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            if (wr) begin
                case (avs.address)
                    3'd1:    rise_en_q <= avs.writedata[WIDTH-1:0];
                    3'd2:    mask_q    <= avs.writedata[WIDTH-1:0];
                    3'd4:    fall_en_q <= avs.writedata[WIDTH-1:0];
                    3'd5:    flen_q    <= avs.writedata[FILT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign avs.readdata = rdata_q;
    assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_multi_edge_irq_pio.sv
// Testbench for multi_edge_irq_pio: directed scenarios plus randomized pulse
// traffic, checked every cycle against a rule-level reference model.
module tb_multi_edge_irq_pio;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] in_port = 8'h00;
    logic       irq;
    int         errors = 0;
    int         checks = 0;

    multi_edge_irq_pio_if bus();

    multi_edge_irq_pio #(.WIDTH(8), .SYNC_STAGES(2), .FILT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model state: past input samples, filtered value, run length of
    // consecutive disagreeing cycles per channel, and the register file.
    logic [7:0]  m_past [2];
    logic [7:0]  m_filt, m_rise, m_fall, m_mask, m_cap;
    int          m_flen;
    int          m_run [8];
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_past[0] = '0; m_past[1] = '0;
        m_filt = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
        m_flen = 0; m_rd = '0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0: return {24'h0, m_filt};
            1: return {24'h0, m_rise};
            2: return {24'h0, m_mask};
            3: return {24'h0, m_cap};
            4: return {24'h0, m_fall};
            5: return 32'(m_flen);
            6: return {24'h0, m_cap & m_mask};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the model, using the values present before the edge.
    task automatic m_step(input logic [7:0] pin, input logic w, input int a, input logic [31:0] wd);
        logic [7:0] s, nf, clr;
        m_rd = m_read(a);
        s = m_past[1];
        m_past[1] = m_past[0];
        m_past[0] = pin;
        nf = m_filt;
        for (int i = 0; i < 8; i++) begin
            if (s[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] > m_flen) begin
                    nf[i] = s[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        clr = (w && a == 3) ? wd[7:0] : 8'h00;
        m_cap = (m_cap & ~clr) | (nf & ~m_filt & m_rise) | (~nf & m_filt & m_fall);
        m_filt = nf;
        if (w) begin
            case (a)
                1: m_rise = wd[7:0];
                2: m_mask = wd[7:0];
                4: m_fall = wd[7:0];
                5: m_flen = int'(wd[7:0]);
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        logic [7:0]  pin;
        logic        w;
        int          a;
        logic [31:0] wd;
        pin = in_port;
        w   = bus.chipselect & ~bus.write_n;
        a   = int'(bus.address);
        wd  = bus.writedata;
        @(posedge clk);
        #1;
        if (!reset_n) m_reset();
        else          m_step(pin, w, a, wd);
        chk("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        chk("model_readdata", bus.readdata, m_rd);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 3'(a);
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        bus.address = 3'(a);
        tick();
        v = bus.readdata;
    endtask

    initial begin
        logic [31:0] v;
        int          hi;
        int          rem [8];

        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        m_reset();

        // T1: reset with inputs high, then every register reads 0
        #1;
        in_port = 8'hFF;
        reset_n = 1'b0;
        #1;
        chk("t1_rst_readdata", bus.readdata, 32'h0);
        chk("t1_rst_irq", {31'h0, irq}, 32'h0);
        repeat (3) tick();
        in_port = 8'h00;
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(a, v);
            chk("t1_reg_zero", v, 32'h0);
        end

        // T2: rising capture with filt_len=0, latency 3 clocks, then W1C
        wr(5, 0); wr(1, 32'h01); wr(2, 32'h01);
        in_port[0] = 1'b1;
        tick(); chk("t2_irq_c1", {31'h0, irq}, 32'h0);
        tick(); chk("t2_irq_c2", {31'h0, irq}, 32'h0);
        tick(); chk("t2_irq_c3", {31'h0, irq}, 32'h1);
        rd(3, v); chk("t2_cap", v, 32'h01);
        wr(3, 32'h01); chk("t2_irq_clr", {31'h0, irq}, 32'h0);

        // T3: glitch filter, filt_len=4, fall capture on bit 2
        wr(1, 0); wr(4, 32'h04); wr(2, 32'hFF); wr(5, 4); wr(3, 32'hFF);
        bus.address = 3'd0;
        hi = 0;
        in_port[2] = 1'b1;
        repeat (4) begin tick(); hi += int'(bus.readdata[2]); end
        in_port[2] = 1'b0;
        repeat (12) begin tick(); hi += int'(bus.readdata[2]); end
        chk("t3_short_data", 32'(hi), 32'h0);
        rd(3, v); chk("t3_short_cap", v, 32'h0);
        bus.address = 3'd0;
        hi = 0;
        in_port[2] = 1'b1;
        repeat (5) begin tick(); hi += int'(bus.readdata[2]); end
        in_port[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            hi += int'(bus.readdata[2]);
            if (k == 6) chk("t3_fall_c6", {31'h0, irq}, 32'h0);
            if (k == 7) chk("t3_fall_c7", {31'h0, irq}, 32'h1);
        end
        repeat (10) begin tick(); hi += int'(bus.readdata[2]); end
        chk("t3_data_pulse", 32'(hi), 32'd5);

        // T4: both edges on bit 7, clear re-arms, irq_stat follows mask
        wr(5, 0); wr(1, 32'h80); wr(4, 32'h80); wr(2, 32'h80); wr(3, 32'hFF);
        in_port[7] = 1'b1;
        repeat (3) tick();
        chk("t4_rise_irq", {31'h0, irq}, 32'h1);
        rd(6, v); chk("t4_stat", v, 32'h80);
        wr(3, 32'h80); chk("t4_clr_irq", {31'h0, irq}, 32'h0);
        repeat (15) tick();
        in_port[7] = 1'b0;
        repeat (2) tick();
        chk("t4_fall_c2", {31'h0, irq}, 32'h0);
        tick();
        chk("t4_fall_irq", {31'h0, irq}, 32'h1);
        wr(2, 0); chk("t4_mask_off_irq", {31'h0, irq}, 32'h0);
        rd(6, v); chk("t4_stat_masked", v, 32'h0);
        rd(3, v); chk("t4_cap_held", v, 32'h80);
        wr(2, 32'h80); chk("t4_mask_on_irq", {31'h0, irq}, 32'h1);
        wr(3, 32'h80); chk("t4_clr2_irq", {31'h0, irq}, 32'h0);

        // T5: W1C in the same cycle as a qualifying edge on bit 3
        wr(1, 32'h08); wr(4, 0); wr(2, 32'h08); wr(3, 32'hFF);
        in_port[3] = 1'b1;
        tick(); tick();
        wr(3, 32'h08);
        chk("t5_irq", {31'h0, irq}, 32'h1);
        rd(3, v); chk("t5_cap", v & 32'h08, 32'h08);

        // T6a: lower filt_len from 20 to 2 while a count is running
        in_port = 8'h00;
        wr(5, 20); wr(1, 32'hFF); wr(4, 0); wr(2, 32'hFF);
        repeat (30) tick();
        wr(3, 32'hFF);
        chk("t6_settled_irq", {31'h0, irq}, 32'h0);
        in_port[1] = 1'b1;
        repeat (10) tick();
        wr(5, 2);
        chk("t6_lower_before", {31'h0, irq}, 32'h0);
        tick();
        chk("t6_lower_after", {31'h0, irq}, 32'h1);

        // T6b: random pulse widths 1..40 with random bus traffic
        wr(5, 3); wr(1, $urandom); wr(4, $urandom); wr(2, $urandom);
        for (int i = 0; i < 8; i++) rem[i] = int'($urandom_range(1, 40));
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 8; i++) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    in_port[i] = ~in_port[i];
                    rem[i] = int'($urandom_range(1, 40));
                end
            end
            if (c == 1500) begin
                reset_n = 1'b0;
                #1;
                m_reset();
                chk("t6_async_rst_irq", {31'h0, irq}, 32'h0);
                chk("t6_async_rst_rd", bus.readdata, 32'h0);
                tick();
                reset_n = 1'b1;
                wr(1, 32'hFF); wr(4, 32'hFF); wr(2, 32'hFF);
            end else if (c == 800) begin
                wr(5, 20);
            end else if (c == 815) begin
                wr(5, 2);
            end else if ($urandom_range(0, 7) == 0) begin
                int a;
                logic [31:0] d;
                a = int'($urandom_range(0, 7));
                d = $urandom;
                if (a == 5) d = d & 32'h7;
                wr(a, d);
            end else begin
                bus.address = 3'($urandom_range(0, 7));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
